// File: rtl/reg_bank_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_param_if
//  Purpose  : Bus bundle between the register bank and its users. It carries
//             NRD read ports and one write port, plus the written-since-reset
//             bitmap.
//  Signals  : rd_en    [NRD]        per-port read request        (master->slave)
//             rd_addr  [NRD*AW]     packed read addresses        (master->slave)
//             rd_data  [NRD*WIDTH]  packed registered read data  (slave->master)
//             rd_valid [NRD]        rd_data slice updated        (slave->master)
//             wr_en                 write request                (master->slave)
//             wr_addr  [AW]         write address                (master->slave)
//             wr_data  [WIDTH]      write data                   (master->slave)
//             written  [DEPTH]      written-since-reset bitmap   (slave->master)
//  Revision : 1.0  initial release
// ============================================================================
interface reg_bank_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NRD-1:0]       rd_en;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_valid;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic [DEPTH-1:0]     written;

  // Requesting side (decode / write-back)
  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_valid, written
  );

  // Register bank side
  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_valid, written
  );
endinterface
`default_nettype wire

// File: rtl/reg_bank_param.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_param
//  Purpose  : Parametrised register bank with NRD registered read ports and a
//             single write port. Reads have one cycle of latency and see a
//             write issued on the same edge (write-to-read bypass). Register 0
//             can optionally be hardwired to zero. A per-register bitmap
//             records which registers have been written since reset.
//  Ports    : clk  - clock, all state updates on the rising edge
//             rst  - synchronous, active-high reset
//             bus  - reg_bank_param_if.slave (read ports, write port, bitmap)
//  Params   : WIDTH, DEPTH (power of two, >=2), NRD (1..4), ZERO_R0,
//             RST_VAL (packed reset image, reg i = RST_VAL[i*WIDTH +: WIDTH])
//  Revision : 1.0  initial release
// ============================================================================
module reg_bank_param #(
  parameter int                     WIDTH   = 32,
  parameter int                     DEPTH   = 8,
  parameter int                     NRD     = 2,
  parameter int                     ZERO_R0 = 0,
  parameter logic [DEPTH*WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_bank_param_if.slave      bus
);

  localparam int AW = $clog2(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]     regs_q [DEPTH];
  logic [WIDTH-1:0]     regs_d [DEPTH];
  logic [DEPTH-1:0]     written_q;
  logic [DEPTH-1:0]     written_d;
  logic [NRD*WIDTH-1:0] rd_data_q;
  logic [NRD*WIDTH-1:0] rd_data_d;
  logic [NRD-1:0]       rd_valid_q;
  logic [NRD-1:0]       rd_valid_d;

  // A write "lands" unless it targets the hardwired-zero register. The same
  // qualified strobe drives storage, the bitmap and the bypass path, so a
  // dropped write can never leak through any of them.
  logic wr_fire;
  assign wr_fire = bus.wr_en && !((ZERO_R0 != 0) && (bus.wr_addr == '0));

  // Reset image for one register; the hardwired-zero register ignores RST_VAL.
  function automatic logic [WIDTH-1:0] rst_word(input int idx);
    if ((ZERO_R0 != 0) && (idx == 0)) begin
      return '0;
    end
    return RST_VAL[idx*WIDTH +: WIDTH];
  endfunction

  // --------------------------------------------------------------------------
  // Write path: next-state of storage and written bitmap
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    written_d = written_q;
    if (wr_fire) begin
      regs_d[bus.wr_addr]    = bus.wr_data;
      written_d[bus.wr_addr] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Read path: one independent mux per port
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < NRD; p++) begin : g_rd_port
    logic [AW-1:0]    addr;
    logic             is_zero_reg;
    logic             bypass;
    logic [WIDTH-1:0] word;

    assign addr        = bus.rd_addr[p*AW +: AW];
    assign is_zero_reg = (ZERO_R0 != 0) && (addr == '0);
    // Storage still holds the old value on this edge, so the in-flight
    // write data is forwarded to keep read-after-write coherent.
    assign bypass      = wr_fire && (addr == bus.wr_addr);
    assign word        = is_zero_reg ? '0
                       : bypass      ? bus.wr_data
                       :               regs_q[addr];

    // Idle ports keep their last delivered value.
    assign rd_data_d[p*WIDTH +: WIDTH] = bus.rd_en[p] ? word
                                                      : rd_data_q[p*WIDTH +: WIDTH];
  end

  assign rd_valid_d = bus.rd_en;

  // --------------------------------------------------------------------------
  // Registers. Reset has priority, so reads and writes presented in a reset
  // cycle are discarded.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= rst_word(i);
      end
      written_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      written_q  <= written_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.written  = written_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_bank_param
//  Purpose  : Self-checking bench for reg_bank_param. Two instances share the
//             same stimulus: dut0 (ZERO_R0=0) and dut1 (ZERO_R0=1). A
//             behavioural array model predicts both.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_bank_param;

  localparam int W = 32;
  localparam int D = 8;
  localparam int N = 2;

  // dut0: reg1=7, reg3=14, reg4=0x44
  localparam logic [D*W-1:0] RV0 = (256'd7 << 32) | (256'd14 << 96) | (256'h44 << 128);
  // dut1: reg0=0x99 (must be masked to 0), reg1=0x11, reg5=0x55
  localparam logic [D*W-1:0] RV1 = 256'h99 | (256'h11 << 32) | (256'h55 << 160);

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]   rd_en;
  logic [N*3-1:0] rd_addr;
  logic           wr_en;
  logic [2:0]     wr_addr;
  logic [W-1:0]   wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bank_param_if #(.WIDTH(W), .DEPTH(D), .NRD(N)) bus0 ();
  reg_bank_param_if #(.WIDTH(W), .DEPTH(D), .NRD(N)) bus1 ();

  assign bus0.rd_en = rd_en;  assign bus0.rd_addr = rd_addr;
  assign bus0.wr_en = wr_en;  assign bus0.wr_addr = wr_addr;  assign bus0.wr_data = wr_data;
  assign bus1.rd_en = rd_en;  assign bus1.rd_addr = rd_addr;
  assign bus1.wr_en = wr_en;  assign bus1.wr_addr = wr_addr;  assign bus1.wr_data = wr_data;

  reg_bank_param #(.WIDTH(W), .DEPTH(D), .NRD(N), .ZERO_R0(0), .RST_VAL(RV0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  reg_bank_param #(.WIDTH(W), .DEPTH(D), .NRD(N), .ZERO_R0(1), .RST_VAL(RV1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  logic [N*W-1:0] obs_data  [2];
  logic [N-1:0]   obs_valid [2];
  logic [D-1:0]   obs_wr    [2];
  assign obs_data[0] = bus0.rd_data;  assign obs_valid[0] = bus0.rd_valid;  assign obs_wr[0] = bus0.written;
  assign obs_data[1] = bus1.rd_data;  assign obs_valid[1] = bus1.rd_valid;  assign obs_wr[1] = bus1.written;

  // --------------------------------------------------------------------------
  // Reference model: plain arrays updated from the behavioural rules
  // --------------------------------------------------------------------------
  logic [W-1:0]   m_regs  [2][D];
  logic [D-1:0]   m_wr    [2];
  logic [N*W-1:0] m_data  [2];
  logic [N-1:0]   m_valid [2];

  function automatic logic [W-1:0] reset_word(input int k, input int i);
    logic [D*W-1:0] rv;
    rv = (k == 0) ? RV0 : RV1;
    if (k == 1 && i == 0) return '0;
    return rv[i*W +: W];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < D; i++) m_regs[k][i] = reset_word(k, i);
        m_wr[k]    = '0;
        m_data[k]  = '0;
        m_valid[k] = '0;
      end else begin
        m_valid[k] = rd_en;
        for (int p = 0; p < N; p++) begin
          if (rd_en[p]) begin
            int a;
            a = int'(rd_addr[p*3 +: 3]);
            if (k == 1 && a == 0)                    m_data[k][p*W +: W] = '0;
            else if (wr_en && int'(wr_addr) == a)    m_data[k][p*W +: W] = wr_data;
            else                                     m_data[k][p*W +: W] = m_regs[k][a];
          end
        end
        if (wr_en && !(k == 1 && wr_addr == 3'd0)) begin
          m_regs[k][wr_addr] = wr_data;
          m_wr[k][wr_addr]   = 1'b1;
        end
      end
    end
  endtask

  // One clock: model advances with the DUT edge, outputs sampled on negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    idle(); rst = 1'b1;
    tick();
    idle(); rd_en = 2'b11; rd_addr = {3'd3, 3'd1};
    tick();
    checks++; if (obs_data[0] !== {32'd14, 32'd7}) begin errors++;
      $display("FAIL reset_rd_data dut0: got %h expected %h", obs_data[0], {32'd14, 32'd7}); end
    checks++; if (obs_valid[0] !== 2'b11) begin errors++;
      $display("FAIL reset_rd_valid dut0: got %b expected 11", obs_valid[0]); end
    checks++; if (obs_wr[0] !== 8'h00 || obs_wr[1] !== 8'h00) begin errors++;
      $display("FAIL reset_written: got %h/%h expected 00/00", obs_wr[0], obs_wr[1]); end
    checks++; if (obs_data[1] !== {32'd0, 32'h11}) begin errors++;
      $display("FAIL reset_rd_data dut1: got %h expected %h", obs_data[1], {32'd0, 32'h11}); end
    // Hardwired-zero register ignores its nonzero reset image
    rd_addr = {3'd5, 3'd0};
    tick();
    checks++; if (obs_data[1] !== {32'h55, 32'h0}) begin errors++;
      $display("FAIL reset_r0_masked dut1: got %h expected %h", obs_data[1], {32'h55, 32'h0}); end
  endtask

  task automatic test_write();
    idle(); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'hDEADBEEF;
    tick();
    idle(); rd_en = 2'b01; rd_addr = {3'd0, 3'd5};
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++; if (obs_data[k][31:0] !== 32'hDEADBEEF) begin errors++;
        $display("FAIL write_read dut%0d: got %h expected deadbeef", k, obs_data[k][31:0]); end
      checks++; if (obs_wr[k] !== 8'b0010_0000) begin errors++;
        $display("FAIL write_bitmap dut%0d: got %b expected 00100000", k, obs_wr[k]); end
    end
    checks++; if (obs_valid[0] !== 2'b01) begin errors++;
      $display("FAIL write_rd_valid dut0: got %b expected 01", obs_valid[0]); end
  endtask

  task automatic test_bypass();
    idle(); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h1234;
    rd_en = 2'b11; rd_addr = {3'd2, 3'd2};
    tick();
    idle();
    for (int k = 0; k < 2; k++) begin
      checks++; if (obs_data[k] !== {32'h1234, 32'h1234}) begin errors++;
        $display("FAIL bypass dut%0d: got %h expected %h", k, obs_data[k], {32'h1234, 32'h1234}); end
    end
  endtask

  task automatic test_zero_r0();
    idle(); wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hFFFF;
    rd_en = 2'b01; rd_addr = {3'd0, 3'd0};
    tick();
    checks++; if (obs_data[1][31:0] !== 32'h0) begin errors++;
      $display("FAIL zero_r0_same_cycle dut1: got %h expected 0", obs_data[1][31:0]); end
    checks++; if (obs_data[0][31:0] !== 32'hFFFF) begin errors++;
      $display("FAIL r0_bypass dut0: got %h expected ffff", obs_data[0][31:0]); end
    idle(); rd_en = 2'b01; rd_addr = {3'd0, 3'd0};
    tick();
    checks++; if (obs_data[1][31:0] !== 32'h0 || obs_valid[1] !== 2'b01) begin errors++;
      $display("FAIL zero_r0_next dut1: got %h/%b expected 0/01", obs_data[1][31:0], obs_valid[1]); end
    checks++; if (obs_wr[1][0] !== 1'b0) begin errors++;
      $display("FAIL zero_r0_bitmap dut1: got %b expected 0", obs_wr[1][0]); end
    checks++; if (obs_wr[0][0] !== 1'b1) begin errors++;
      $display("FAIL r0_bitmap dut0: got %b expected 1", obs_wr[0][0]); end
  endtask

  task automatic test_hold();
    idle(); wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'hAA;
    tick();
    idle(); rd_en = 2'b01; rd_addr = {3'd0, 3'd6};
    tick();
    checks++; if (obs_data[0][31:0] !== 32'hAA) begin errors++;
      $display("FAIL hold_first dut0: got %h expected aa", obs_data[0][31:0]); end
    for (int c = 0; c < 3; c++) begin
      // Keep overwriting reg6 so a port that re-reads would be caught
      idle(); wr_en = 1'b1; wr_addr = 3'd6; wr_data = $urandom; rd_addr = {3'd6, 3'd6};
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++; if (obs_data[k][31:0] !== 32'hAA || obs_valid[k] !== 2'b00) begin errors++;
          $display("FAIL hold_cycle%0d dut%0d: got %h/%b expected aa/00", c, k, obs_data[k][31:0], obs_valid[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    idle(); rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'h55;
    rd_en = 2'b11; rd_addr = {3'd4, 3'd4};
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++; if (obs_valid[k] !== 2'b00 || obs_data[k] !== '0) begin errors++;
        $display("FAIL rst_mid_read dut%0d: got %h/%b expected 0/00", k, obs_data[k], obs_valid[k]); end
      checks++; if (obs_wr[k] !== 8'h00) begin errors++;
        $display("FAIL rst_mid_bitmap dut%0d: got %b expected 00000000", k, obs_wr[k]); end
    end
    idle(); rd_en = 2'b01; rd_addr = {3'd0, 3'd4};
    tick();
    checks++; if (obs_data[0][31:0] !== 32'h44) begin errors++;
      $display("FAIL rst_mid_reg4 dut0: got %h expected 44", obs_data[0][31:0]); end
    checks++; if (obs_data[1][31:0] !== 32'h0) begin errors++;
      $display("FAIL rst_mid_reg4 dut1: got %h expected 0", obs_data[1][31:0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 39) == 0);
      rd_en   = N'($urandom);
      // Narrow address range half the time to provoke bypass and collisions
      if ($urandom_range(0, 1) == 1) begin
        rd_addr = {3'($urandom_range(0, 1)), 3'($urandom_range(0, 1))};
        wr_addr = 3'($urandom_range(0, 1));
      end else begin
        rd_addr = 6'($urandom);
        wr_addr = 3'($urandom);
      end
      wr_en   = ($urandom_range(0, 2) != 0);
      wr_data = $urandom;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++; if (obs_data[k] !== m_data[k]) begin errors++;
          $display("FAIL rand_rd_data c%0d dut%0d: got %h expected %h", c, k, obs_data[k], m_data[k]); end
        checks++; if (obs_valid[k] !== m_valid[k]) begin errors++;
          $display("FAIL rand_rd_valid c%0d dut%0d: got %b expected %b", c, k, obs_valid[k], m_valid[k]); end
        checks++; if (obs_wr[k] !== m_wr[k]) begin errors++;
          $display("FAIL rand_written c%0d dut%0d: got %b expected %b", c, k, obs_wr[k], m_wr[k]); end
      end
    end
    idle();
  endtask

  initial begin
    idle(); rst = 1'b1;
    tick();
    tick();
    test_reset();
    test_write();
    test_bypass();
    test_zero_r0();
    test_hold();
    test_reset_mid();
    test_random();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
